// File: rtl/enigma_pkg.sv
// Shared types and constants for the ENIGMA front-end blocks.
package enigma_pkg;

    localparam int ROTOR_LEN = 128;
    localparam int SYM_W     = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROTOR,
        GAP,
        CODE,
        DRAIN
    } seq_state_t;

    typedef logic [SYM_W-1:0] sym_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/enigma_frame_sequencer_if.sv
// Upstream symbol stream plus the core-facing replay bus of the frame sequencer.
interface enigma_frame_sequencer_if;
    import enigma_pkg::*;

    // upstream valid/ready symbol stream
    logic s_valid;
    logic s_ready;
    sym_t s_data;
    logic s_mode;
    logic s_last;

    // replay towards the ENIGMA core
    logic enc_in_valid;
    logic enc_in_valid_2;
    logic enc_crypt_mode;
    sym_t enc_code_in;
    logic enc_out_valid;

    // status
    logic busy;
    logic err_short;
    logic err_long;

    modport slave (
        input  s_valid, s_data, s_mode, s_last, enc_out_valid,
        output s_ready, enc_in_valid, enc_in_valid_2, enc_crypt_mode, enc_code_in,
        output busy, err_short, err_long
    );

    modport master (
        output s_valid, s_data, s_mode, s_last, enc_out_valid,
        input  s_ready, enc_in_valid, enc_in_valid_2, enc_crypt_mode, enc_code_in,
        input  busy, err_short, err_long
    );

endinterface

// File: rtl/enigma_frame_buf.sv
// Frame store: one write port, one combinational read port, contents not reset.
module enigma_frame_buf
    import enigma_pkg::*;
#(
    parameter int DEPTH = ROTOR_LEN + 64,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  sym_t          wdata,
    input  logic [AW-1:0] raddr,
    output sym_t          rdata
);

    sym_t mem [DEPTH];

    // write port; a dropped frame simply gets overwritten by the next one
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/enigma_frame_sequencer.sv
// Buffers one upstream frame, then replays it to the ENIGMA core as a stall-free
// rotor burst, a fixed gap and a code burst, and waits for every core output.
module enigma_frame_sequencer
    import enigma_pkg::*;
#(
    parameter int MAX_CODE   = 64,
    parameter int GAP_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    enigma_frame_sequencer_if.slave   bus
);

    localparam int DEPTH = ROTOR_LEN + MAX_CODE;
    localparam int AW    = cnt_w(DEPTH);
    localparam int LW    = cnt_w(MAX_CODE + 1);
    localparam int GW    = cnt_w(GAP_CYCLES);

    localparam logic [AW-1:0] ROT_BASE = AW'(ROTOR_LEN);
    localparam logic [AW-1:0] ROT_END  = AW'(ROTOR_LEN - 1);
    localparam logic [AW-1:0] IDX_MAX  = AW'(ROTOR_LEN - 1 + MAX_CODE);
    localparam logic [GW-1:0] GAP_END  = GW'(GAP_CYCLES - 1);

    seq_state_t      state;
    logic [AW-1:0]   wr_cnt;
    logic [AW-1:0]   rd_cnt;
    logic [LW-1:0]   out_cnt;
    logic [LW-1:0]   code_len;
    logic [GW-1:0]   gap_cnt;
    logic            mode_q;
    logic            busy_q;
    logic            err_short_q;
    logic            err_long_q;
    logic            enc_in_valid_q;
    logic            enc_in_valid_2_q;
    logic            enc_crypt_mode_q;
    sym_t            enc_code_in_q;

    logic            s_ready;
    logic            xfer;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_addr;
    sym_t            rd_data;

    // ready only while collecting a frame, and held low while reset is asserted
    assign s_ready = ~rst & ((state == IDLE) | (state == LOAD));
    assign xfer    = bus.s_valid & s_ready;

    // first symbol of a frame always lands at 0; wr_cnt points at the next slot
    assign wr_addr = (state == IDLE) ? '0 : wr_cnt;

    // code words live right after the rotor symbols
    assign rd_addr = (state == CODE) ? ROT_BASE + rd_cnt : rd_cnt;

    enigma_frame_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (xfer),
        .waddr (wr_addr),
        .wdata (bus.s_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // frame sequencing FSM; all core-facing outputs are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            wr_cnt           <= '0;
            rd_cnt           <= '0;
            out_cnt          <= '0;
            code_len         <= '0;
            gap_cnt          <= '0;
            mode_q           <= 1'b0;
            busy_q           <= 1'b0;
            err_short_q      <= 1'b0;
            err_long_q       <= 1'b0;
            enc_in_valid_q   <= 1'b0;
            enc_in_valid_2_q <= 1'b0;
            enc_crypt_mode_q <= 1'b0;
            enc_code_in_q    <= '0;
        end else begin
            err_short_q      <= 1'b0;
            err_long_q       <= 1'b0;
            enc_in_valid_q   <= 1'b0;
            enc_in_valid_2_q <= 1'b0;
            enc_crypt_mode_q <= 1'b0;
            enc_code_in_q    <= '0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        mode_q <= bus.s_mode;
                        if (bus.s_last) begin
                            // a one-symbol frame can never hold the rotors
                            err_short_q <= 1'b1;
                        end else begin
                            wr_cnt <= AW'(1);
                            busy_q <= 1'b1;
                            state  <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        if (bus.s_last && (wr_cnt < ROT_BASE)) begin
                            err_short_q <= 1'b1;
                            busy_q      <= 1'b0;
                            wr_cnt      <= '0;
                            state       <= IDLE;
                        end else if (bus.s_last || (wr_cnt == IDX_MAX)) begin
                            // a full buffer without s_last is closed as if s_last had come
                            err_long_q <= ~bus.s_last;
                            code_len   <= LW'(wr_cnt - ROT_END);
                            wr_cnt     <= '0;
                            rd_cnt     <= '0;
                            state      <= ROTOR;
                        end else begin
                            wr_cnt <= wr_cnt + AW'(1);
                        end
                    end
                end
                ROTOR: begin
                    enc_in_valid_q   <= 1'b1;
                    enc_code_in_q    <= rd_data;
                    enc_crypt_mode_q <= (rd_cnt == '0) & mode_q;
                    if (rd_cnt == ROT_END) begin
                        rd_cnt  <= '0;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        rd_cnt <= rd_cnt + AW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_END) state <= CODE;
                    else                    gap_cnt <= gap_cnt + GW'(1);
                end
                CODE: begin
                    enc_in_valid_2_q <= 1'b1;
                    enc_code_in_q    <= rd_data;
                    if (LW'(rd_cnt + AW'(1)) == code_len) begin
                        rd_cnt  <= '0;
                        out_cnt <= '0;
                        state   <= DRAIN;
                    end else begin
                        rd_cnt <= rd_cnt + AW'(1);
                    end
                end
                DRAIN: begin
                    // core outputs arriving in any other state are not counted
                    if (bus.enc_out_valid) begin
                        if (LW'(out_cnt + LW'(1)) == code_len) begin
                            out_cnt <= '0;
                            busy_q  <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            out_cnt <= out_cnt + LW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_ready        = s_ready;
    assign bus.enc_in_valid   = enc_in_valid_q;
    assign bus.enc_in_valid_2 = enc_in_valid_2_q;
    assign bus.enc_crypt_mode = enc_crypt_mode_q;
    assign bus.enc_code_in    = enc_code_in_q;
    assign bus.busy           = busy_q;
    assign bus.err_short      = err_short_q;
    assign bus.err_long       = err_long_q;

endmodule
